// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an external SPI master and the register bank.
// The master drives SCLK/SSEL/MOSI and the bank returns MISO.
interface spi_reg_bank_if;
  logic SCLK;
  logic SSEL;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SSEL, output MOSI, input MISO);
  modport slave  (input SCLK, input SSEL, input MOSI, output MISO);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-mode-0 register bank: synchronises the pins, decodes {rw,addr}+data frames and
// stages writes, which are committed to the pixel/audio outputs at frame_sync.
module spi_reg_bank #(
  parameter bit         COMMIT_ON_FRAME = 1'b1,
  parameter logic [7:0] ID_VALUE        = 8'hD5
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_bank_if.slave  spi,
  input  logic           frame_sync,
  output logic [7:0]     background_state,
  output logic [5:0]     solid_color,
  output logic           audio_en
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [2:0] sclk_s;
  logic [1:0] ssel_s, mosi_s;
  logic       sclk_rise, sclk_fall, ssel_hi, mosi_bit;

  state_t     state, state_d;
  logic [7:0] cmd_reg, cmd_d, cmd_next;
  logic [6:0] rx_reg, rx_d;
  logic [7:0] tx_reg, tx_d;
  logic [2:0] bit_cnt, cnt_d;
  logic       miso_q, miso_d;
  logic       wr_en, wr_hit;
  logic [7:0] wr_data, rd_data;

  logic [7:0] st_bg;
  logic [5:0] st_col;
  logic       st_aud;
  logic       pending;

  // SSEL idles high, so its synchroniser resets to the deselected level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      ssel_s <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi.SCLK};
      ssel_s <= {ssel_s[0], spi.SSEL};
      mosi_s <= {mosi_s[0], spi.MOSI};
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign ssel_hi   = ssel_s[1];
  assign mosi_bit  = mosi_s[1];
  assign cmd_next  = {cmd_reg[6:0], mosi_bit};
  assign wr_data   = {rx_reg, mosi_bit};
  assign wr_hit    = wr_en && (cmd_reg[6:0] < 7'd3);

  // Reads return staged values so a master sees its own write before commit.
  always_comb begin
    rd_data = 8'h00;
    if (cmd_next[7]) begin
      case (cmd_next[6:0])
        7'h00:   rd_data = st_bg;
        7'h01:   rd_data = {2'b00, st_col};
        7'h02:   rd_data = {7'b0, st_aud};
        7'h03:   rd_data = ID_VALUE;
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    cmd_d   = cmd_reg;
    rx_d    = rx_reg;
    tx_d    = tx_reg;
    cnt_d   = bit_cnt;
    wr_en   = 1'b0;
    if (ssel_hi) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: if (sclk_rise) begin
          cmd_d = cmd_next;
          cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_d = DATA;
            cnt_d   = '0;
            tx_d    = rd_data;
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_d  = wr_data[6:0];
            cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_d = DONE;
              wr_en   = ~cmd_reg[7];
            end
          end else if (sclk_fall && bit_cnt != 3'd0) begin
            tx_d = {tx_reg[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
    // MISO is registered from next-state values so it tracks tx_reg[7] without lag.
    miso_d = (state_d == DATA) ? tx_d[7] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_reg <= '0;
      rx_reg  <= '0;
      tx_reg  <= '0;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cmd_reg <= cmd_d;
      rx_reg  <= rx_d;
      tx_reg  <= tx_d;
      bit_cnt <= cnt_d;
      miso_q  <= miso_d;
    end
  end

  assign spi.MISO = miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_bg  <= '0;
      st_col <= '0;
      st_aud <= 1'b0;
    end else if (wr_en) begin
      case (cmd_reg[6:0])
        7'h00:   st_bg  <= wr_data;
        7'h01:   st_col <= wr_data[5:0];
        7'h02:   st_aud <= wr_data[0];
        default: ;
      endcase
    end
  end

  // A write coinciding with frame_sync commits the old staged values and stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      background_state <= '0;
      solid_color      <= '0;
      audio_en         <= 1'b0;
      pending          <= 1'b0;
    end else if (COMMIT_ON_FRAME) begin
      if (frame_sync && pending) begin
        background_state <= st_bg;
        solid_color      <= st_col;
        audio_en         <= st_aud;
      end
      if (wr_hit)          pending <= 1'b1;
      else if (frame_sync) pending <= 1'b0;
    end else begin
      background_state <= st_bg;
      solid_color      <= st_col;
      audio_en         <= st_aud;
      pending          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: table of SPI frames with expected read data and
// committed outputs, plus hand sequences for reset, abort and frame_sync collision.
module tb_spi_reg_bank;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] background_state;
  logic [5:0] solid_color;
  logic       audio_en;
  logic [7:0] rd;

  int n_cmp = 0;
  int n_bad = 0;

  spi_reg_bank_if spi ();

  spi_reg_bank #(.COMMIT_ON_FRAME(1'b1), .ID_VALUE(8'hD5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .spi              (spi),
    .frame_sync       (frame_sync),
    .background_state (background_state),
    .solid_color      (solid_color),
    .audio_en         (audio_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    bit         frame;
    logic [7:0] exp_miso;
    logic [7:0] exp_bg;
    logic [5:0] exp_col;
    logic       exp_aud;
  } vec_t;

  vec_t tbl[13];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] bg, input logic [5:0] col,
                            input logic aud);
    check({name, " bg"}, background_state, bg);
    check({name, " col"}, {2'b00, solid_color}, {2'b00, col});
    check({name, " aud"}, {7'b0, audio_en}, {7'b0, aud});
  endtask

  task automatic frame_pulse();
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    tick(1);
  endtask

  // Mode-0 master: MOSI changes while SCLK low, MISO sampled just before each rise.
  task automatic spi_xfer(input logic [7:0] c, input logic [7:0] d, input int nbits,
                          input bit fs_last, input bit keep_sel, output logic [7:0] r);
    logic [15:0] w;
    w = {c, d};
    r = 8'h00;
    spi.SSEL = 1'b0;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      spi.MOSI = w[15-i];
      tick(H);
      if (i >= 8) r = {r[6:0], spi.MISO};
      spi.SCLK = 1'b1;
      if (i == 15 && fs_last) begin
        tick(2);
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        tick(H - 3);
      end else begin
        tick(H);
      end
      spi.SCLK = 1'b0;
    end
    if (!keep_sel) begin
      tick(H);
      spi.SSEL = 1'b1;
      spi.MOSI = 1'b0;
      tick(H);
    end
  endtask

  initial begin
    spi.SCLK = 1'b0;
    spi.SSEL = 1'b1;
    spi.MOSI = 1'b0;

    tbl[0]  = '{8'h01, 8'hFF, 1'b0, 8'h00, 8'hA5, 6'h00, 1'b0};
    tbl[1]  = '{8'h81, 8'h00, 1'b1, 8'h3F, 8'hA5, 6'h3F, 1'b0};
    tbl[2]  = '{8'h83, 8'h00, 1'b0, 8'hD5, 8'hA5, 6'h3F, 1'b0};
    tbl[3]  = '{8'h03, 8'h00, 1'b0, 8'h00, 8'hA5, 6'h3F, 1'b0};
    tbl[4]  = '{8'h83, 8'h00, 1'b0, 8'hD5, 8'hA5, 6'h3F, 1'b0};
    tbl[5]  = '{8'h90, 8'h00, 1'b0, 8'h00, 8'hA5, 6'h3F, 1'b0};
    tbl[6]  = '{8'h80, 8'h00, 1'b0, 8'hA5, 8'hA5, 6'h3F, 1'b0};
    tbl[7]  = '{8'h02, 8'hFF, 1'b1, 8'h00, 8'hA5, 6'h3F, 1'b1};
    tbl[8]  = '{8'h82, 8'h00, 1'b0, 8'h01, 8'hA5, 6'h3F, 1'b1};
    tbl[9]  = '{8'h7F, 8'h12, 1'b1, 8'h00, 8'hA5, 6'h3F, 1'b1};
    tbl[10] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'hA5, 6'h3F, 1'b1};
    tbl[11] = '{8'h00, 8'h5A, 1'b0, 8'h00, 8'hA5, 6'h3F, 1'b1};
    tbl[12] = '{8'h80, 8'h00, 1'b1, 8'h5A, 8'h5A, 6'h3F, 1'b1};

    tick(3);
    check_outs("reset", 8'h00, 6'h00, 1'b0);
    check("reset miso", {7'b0, spi.MISO}, 8'h00);
    rst_n = 1'b1;
    tick(4);

    // Staged write is invisible until the frame_sync pulse.
    spi_xfer(8'h00, 8'hA5, 16, 1'b0, 1'b0, rd);
    check("bg before frame", background_state, 8'h00);
    frame_sync = 1'b1;
    tick(1);
    check("bg after frame", background_state, 8'hA5);
    frame_sync = 1'b0;
    tick(1);

    // Abort after 5 data bits: nothing staged, nothing pending.
    spi_xfer(8'h02, 8'h01, 13, 1'b0, 1'b0, rd);
    spi_xfer(8'h82, 8'h00, 16, 1'b0, 1'b0, rd);
    check("abort staged", rd, 8'h00);
    frame_pulse();
    check_outs("abort", 8'hA5, 6'h00, 1'b0);

    for (int i = 0; i < 13; i++) begin
      spi_xfer(tbl[i].cmd, tbl[i].data, 16, 1'b0, 1'b0, rd);
      if (tbl[i].cmd[7]) check($sformatf("vec%0d miso", i), rd, tbl[i].exp_miso);
      if (tbl[i].frame) frame_pulse();
      check_outs($sformatf("vec%0d", i), tbl[i].exp_bg, tbl[i].exp_col, tbl[i].exp_aud);
    end

    // Write landing on the frame_sync clk: old staged values commit, new one waits.
    spi_xfer(8'h01, 8'h15, 16, 1'b0, 1'b0, rd);
    spi_xfer(8'h00, 8'h3C, 16, 1'b1, 1'b0, rd);
    check_outs("collide", 8'h5A, 6'h15, 1'b1);
    frame_pulse();
    check_outs("collide next", 8'h3C, 6'h15, 1'b1);

    // Reset in the middle of a read frame, then a clean frame.
    spi_xfer(8'h83, 8'h00, 9, 1'b0, 1'b1, rd);
    tick(H);
    check("pre-reset miso", {7'b0, spi.MISO}, 8'h01);
    rst_n = 1'b0;
    tick(1);
    check_outs("mid reset", 8'h00, 6'h00, 1'b0);
    check("mid reset miso", {7'b0, spi.MISO}, 8'h00);
    spi.SSEL = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(H);
    spi_xfer(8'h00, 8'h11, 16, 1'b0, 1'b0, rd);
    frame_pulse();
    check_outs("post reset", 8'h11, 6'h00, 1'b0);
    spi_xfer(8'h83, 8'h00, 16, 1'b0, 1'b0, rd);
    check("post reset id", rd, 8'hD5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
